// File: rtl/sd_tx_dma_filler.sv
// ---------------------------------------------------------------------------
// sd_tx_dma_filler
// Wishbone burst-read DMA master feeding the SD controller's TX data FIFO.
// Fetches xfer_words words starting at start_adr using incrementing bursts,
// pushing each returned word into the (dual-clock) TX FIFO write port.
// A burst is only opened once the FIFO reports room for every beat of it.
//
// Ports
//   clk, rst      : clock and asynchronous active-high reset
//   start, en     : start pulse (accepted only in IDLE) and transfer enable
//   start_adr     : byte address of the first word
//   xfer_words    : number of words to fetch
//   m_wb_*        : Wishbone read master (incrementing bursts, linear BTE)
//   fifo_wr/dat   : TX FIFO write strobe and data
//   fifo_free     : free TX FIFO entries, in words
//   busy/done     : transfer in progress / one-cycle completion pulse
//   bus_err       : sticky bus error flag, cleared by the next start
// ---------------------------------------------------------------------------
module sd_tx_dma_filler #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 16,
  parameter int FREE_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic [AW-1:0]     start_adr,
  input  logic [CNT_W-1:0]  xfer_words,
  output logic [AW-1:0]     m_wb_adr_o,
  output logic [DW/8-1:0]   m_wb_sel_o,
  output logic              m_wb_we_o,
  output logic              m_wb_cyc_o,
  output logic              m_wb_stb_o,
  output logic [2:0]        m_wb_cti_o,
  output logic [1:0]        m_wb_bte_o,
  input  logic [DW-1:0]     m_wb_dat_i,
  input  logic              m_wb_ack_i,
  input  logic              m_wb_err_i,
  output logic              fifo_wr,
  output logic [DW-1:0]     fifo_dat,
  input  logic [FREE_W-1:0] fifo_free,
  output logic              busy,
  output logic              done,
  output logic              bus_err
);

  localparam logic [CNT_W-1:0] BURST_MAX   = CNT_W'(BURST_LEN);
  localparam logic [AW-1:0]    STEP        = AW'(DW / 8);
  localparam logic [2:0]       CTI_CLASSIC = 3'b000;
  localparam logic [2:0]       CTI_INCR    = 3'b010;
  localparam logic [2:0]       CTI_END     = 3'b111;

  typedef enum logic [2:0] {IDLE, CHECK, BURST, GAP, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] beats;
  logic [CNT_W-1:0] blen;
  logic             room;
  logic             last_beat;

  assign m_wb_sel_o = '1;
  assign m_wb_we_o  = 1'b0;
  assign m_wb_bte_o = 2'b00;

  // Length of the next burst and whether the FIFO can absorb all of it.
  // Both operands are zero-extended to a common width before comparing.
  always_comb begin
    blen      = (rem < BURST_MAX) ? rem : BURST_MAX;
    room      = {{CNT_W{1'b0}}, fifo_free} >= {{FREE_W{1'b0}}, blen};
    last_beat = (beats == CNT_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a low enable forces IDLE from anywhere.
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = CHECK;
        CHECK:   if (rem == '0) state_next = DONE;
                 else if (room) state_next = BURST;
        BURST:   if (m_wb_err_i) state_next = DONE;
                 else if (m_wb_ack_i && last_beat) state_next = GAP;
        GAP:     state_next = CHECK;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Registered bus, FIFO and status outputs. An abort wins over any ack
  // in the same cycle, so that beat is never written to the FIFO.
  // cti switches to end-of-burst once only one beat remains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wb_adr_o <= '0;
      m_wb_cyc_o <= 1'b0;
      m_wb_stb_o <= 1'b0;
      m_wb_cti_o <= CTI_CLASSIC;
      fifo_wr    <= 1'b0;
      fifo_dat   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bus_err    <= 1'b0;
      rem        <= '0;
      beats      <= '0;
    end else begin
      fifo_wr <= 1'b0;
      done    <= 1'b0;
      if (!en) begin
        m_wb_cyc_o <= 1'b0;
        m_wb_stb_o <= 1'b0;
        m_wb_cti_o <= CTI_CLASSIC;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              m_wb_adr_o <= start_adr;
              rem        <= xfer_words;
              bus_err    <= 1'b0;
              busy       <= 1'b1;
            end
          end
          CHECK: begin
            if (rem == '0) begin
              done <= 1'b1;
            end else if (room) begin
              m_wb_cyc_o <= 1'b1;
              m_wb_stb_o <= 1'b1;
              beats      <= blen;
              m_wb_cti_o <= (blen == CNT_W'(1)) ? CTI_CLASSIC : CTI_INCR;
            end
          end
          BURST: begin
            if (m_wb_err_i) begin
              m_wb_cyc_o <= 1'b0;
              m_wb_stb_o <= 1'b0;
              m_wb_cti_o <= CTI_CLASSIC;
              bus_err    <= 1'b1;
              done       <= 1'b1;
            end else if (m_wb_ack_i) begin
              m_wb_adr_o <= m_wb_adr_o + STEP;
              rem        <= rem - CNT_W'(1);
              beats      <= beats - CNT_W'(1);
              fifo_dat   <= m_wb_dat_i;
              fifo_wr    <= 1'b1;
              if (last_beat) begin
                m_wb_cyc_o <= 1'b0;
                m_wb_stb_o <= 1'b0;
                m_wb_cti_o <= CTI_CLASSIC;
              end else if (beats == CNT_W'(2)) begin
                m_wb_cti_o <= CTI_END;
              end
            end
          end
          DONE: busy <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
